// File: rtl/id_stage_pkg.sv
// Shared decode constants, ALU-op codes and the instruction decoder for the MIPS ID stage.
// The decoder is a pure function so the top stays focused on operand selection and ID/EX control.
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {OP1_RS, OP1_SHAMT, OP1_ZERO} opnd1_sel_e;
  typedef enum logic [1:0] {OP2_RT, OP2_SEXT, OP2_ZEXT, OP2_LUI} opnd2_sel_e;

  typedef struct packed {
    alu_op_e    alu_op;
    opnd1_sel_e op1_sel;
    opnd2_sel_e op2_sel;
    logic       rd_rs;
    logic       rd_rt;
    logic       we;
    logic [4:0] waddr;
    logic       mem_read;
    logic       mem_write;
    logic       is_beq;
    logic       is_bne;
  } decode_t;

  // Unknown encodings fall out of the defaults as a valid NOP with no reads and no writes.
  function automatic decode_t decode(input logic [31:0] inst);
    decode_t    d;
    logic [5:0] op;
    logic [5:0] fn;
    op        = inst[31:26];
    fn        = inst[5:0];
    d         = '0;
    d.alu_op  = ALU_NOP;
    d.op1_sel = OP1_RS;
    d.op2_sel = OP2_RT;
    case (op)
      OP_RTYPE: begin
        d.rd_rs = 1'b1;
        d.rd_rt = 1'b1;
        d.we    = 1'b1;
        d.waddr = inst[15:11];
        case (fn)
          FN_ADDU: d.alu_op = ALU_ADD;
          FN_SUBU: d.alu_op = ALU_SUB;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_XOR:  d.alu_op = ALU_XOR;
          FN_SLT:  d.alu_op = ALU_SLT;
          FN_SLL, FN_SRL: begin
            d.alu_op  = (fn == FN_SLL) ? ALU_SLL : ALU_SRL;
            d.op1_sel = OP1_SHAMT;
            d.rd_rs   = 1'b0;
          end
          default: begin
            d.rd_rs = 1'b0;
            d.rd_rt = 1'b0;
            d.we    = 1'b0;
            d.waddr = 5'd0;
          end
        endcase
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        d.rd_rs   = 1'b1;
        d.we      = 1'b1;
        d.waddr   = inst[20:16];
        d.op2_sel = (op == OP_ADDIU) ? OP2_SEXT : OP2_ZEXT;
        case (op)
          OP_ADDIU: d.alu_op = ALU_ADD;
          OP_ANDI:  d.alu_op = ALU_AND;
          OP_ORI:   d.alu_op = ALU_OR;
          default:  d.alu_op = ALU_XOR;
        endcase
      end
      OP_LUI: begin
        d.alu_op  = ALU_OR;
        d.op1_sel = OP1_ZERO;
        d.op2_sel = OP2_LUI;
        d.we      = 1'b1;
        d.waddr   = inst[20:16];
      end
      OP_LW: begin
        d.alu_op   = ALU_ADD;
        d.op2_sel  = OP2_SEXT;
        d.rd_rs    = 1'b1;
        d.we       = 1'b1;
        d.waddr    = inst[20:16];
        d.mem_read = 1'b1;
      end
      OP_SW: begin
        d.alu_op    = ALU_ADD;
        d.op2_sel   = OP2_SEXT;
        d.rd_rs     = 1'b1;
        d.rd_rt     = 1'b1;
        d.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d.rd_rs  = 1'b1;
        d.rd_rt  = 1'b1;
        d.is_beq = (op == OP_BEQ);
        d.is_bne = (op == OP_BNE);
      end
      default: ;
    endcase
    if (d.waddr == 5'd0) d.we = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of every ID-stage signal except clock and reset: IF/ID inputs, register-file
// read ports, EX/MEM forwarding, redirect/stall controls and the ID/EX register outputs.
interface id_stage_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);
  logic [PC_W-1:0]   if_pc;
  logic [31:0]       if_inst;
  logic              if_valid;
  logic [4:0]        reg1_addr;
  logic              reg1_read;
  logic [DATA_W-1:0] reg1_data;
  logic [4:0]        reg2_addr;
  logic              reg2_read;
  logic [DATA_W-1:0] reg2_data;
  logic              fwd_ex_we;
  logic [4:0]        fwd_ex_waddr;
  logic [DATA_W-1:0] fwd_ex_wdata;
  logic              fwd_ex_is_load;
  logic              fwd_mem_we;
  logic [4:0]        fwd_mem_waddr;
  logic [DATA_W-1:0] fwd_mem_wdata;
  logic              flush;
  logic              stall_req;
  logic              branch_taken;
  logic [PC_W-1:0]   branch_target;
  logic              idex_valid;
  logic [3:0]        idex_aluop;
  logic [DATA_W-1:0] idex_opnd1;
  logic [DATA_W-1:0] idex_opnd2;
  logic              idex_we;
  logic [4:0]        idex_waddr;
  logic              idex_mem_read;
  logic              idex_mem_write;
  logic [DATA_W-1:0] idex_store_data;

  modport master (
    output if_pc, if_inst, if_valid, reg1_data, reg2_data,
           fwd_ex_we, fwd_ex_waddr, fwd_ex_wdata, fwd_ex_is_load,
           fwd_mem_we, fwd_mem_waddr, fwd_mem_wdata, flush,
    input  reg1_addr, reg1_read, reg2_addr, reg2_read, stall_req, branch_taken, branch_target,
           idex_valid, idex_aluop, idex_opnd1, idex_opnd2, idex_we, idex_waddr,
           idex_mem_read, idex_mem_write, idex_store_data
  );

  modport slave (
    input  if_pc, if_inst, if_valid, reg1_data, reg2_data,
           fwd_ex_we, fwd_ex_waddr, fwd_ex_wdata, fwd_ex_is_load,
           fwd_mem_we, fwd_mem_waddr, fwd_mem_wdata, flush,
    output reg1_addr, reg1_read, reg2_addr, reg2_read, stall_req, branch_taken, branch_target,
           idex_valid, idex_aluop, idex_opnd1, idex_opnd2, idex_we, idex_waddr,
           idex_mem_read, idex_mem_write, idex_store_data
  );
endinterface

// File: rtl/id_operand_fwd.sv
// Forwarding mux for one register-file read port: EX beats MEM beats register file;
// $0 is never forwarded, and a disabled port yields zero.
module id_operand_fwd #(
  parameter int DATA_W = 32
) (
  input  logic              rd_en_i,
  input  logic [4:0]        addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              ex_we_i,
  input  logic [4:0]        ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              mem_we_i,
  input  logic [4:0]        mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ex_hit_o
);
  logic mem_hit;

  // ex_hit_o doubles as the load-use match for this port.
  assign ex_hit_o = rd_en_i & ex_we_i & (ex_waddr_i == addr_i) & (addr_i != 5'd0);
  assign mem_hit  = rd_en_i & mem_we_i & (mem_waddr_i == addr_i) & (addr_i != 5'd0);

  always_comb begin
    if (!rd_en_i)      data_o = '0;
    else if (ex_hit_o) data_o = ex_wdata_i;
    else if (mem_hit)  data_o = mem_wdata_i;
    else               data_o = rf_data_i;
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, operand forwarding, load-use stall, BEQ/BNE
// resolution and the registered ID/EX boundary with flush/stall bubbles.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);
  decode_t           dec;
  logic [4:0]        rs_addr, rt_addr, shamt;
  logic [15:0]       imm;
  logic              rd1_en, rd2_en, ex_hit1, ex_hit2, eq, stall;
  logic [DATA_W-1:0] rs_val, rt_val, opnd1, opnd2;
  logic [PC_W-1:0]   br_offset;

  logic              idex_valid_d, idex_valid_q;
  alu_op_e           idex_aluop_d, idex_aluop_q;
  logic [DATA_W-1:0] idex_opnd1_d, idex_opnd1_q;
  logic [DATA_W-1:0] idex_opnd2_d, idex_opnd2_q;
  logic              idex_we_d, idex_we_q;
  logic [4:0]        idex_waddr_d, idex_waddr_q;
  logic              idex_mem_read_d, idex_mem_read_q;
  logic              idex_mem_write_d, idex_mem_write_q;
  logic [DATA_W-1:0] idex_store_data_d, idex_store_data_q;

  assign rs_addr = bus.if_inst[25:21];
  assign rt_addr = bus.if_inst[20:16];
  assign shamt   = bus.if_inst[10:6];
  assign imm     = bus.if_inst[15:0];
  assign dec     = decode(bus.if_inst);

  assign rd1_en        = dec.rd_rs & ~rst;
  assign rd2_en        = dec.rd_rt & ~rst;
  assign bus.reg1_addr = rs_addr;
  assign bus.reg1_read = rd1_en;
  assign bus.reg2_addr = rt_addr;
  assign bus.reg2_read = rd2_en;

  id_operand_fwd #(.DATA_W(DATA_W)) u_fwd_rs (
    .rd_en_i    (rd1_en),
    .addr_i     (rs_addr),
    .rf_data_i  (bus.reg1_data),
    .ex_we_i    (bus.fwd_ex_we),
    .ex_waddr_i (bus.fwd_ex_waddr),
    .ex_wdata_i (bus.fwd_ex_wdata),
    .mem_we_i   (bus.fwd_mem_we),
    .mem_waddr_i(bus.fwd_mem_waddr),
    .mem_wdata_i(bus.fwd_mem_wdata),
    .data_o     (rs_val),
    .ex_hit_o   (ex_hit1)
  );

  id_operand_fwd #(.DATA_W(DATA_W)) u_fwd_rt (
    .rd_en_i    (rd2_en),
    .addr_i     (rt_addr),
    .rf_data_i  (bus.reg2_data),
    .ex_we_i    (bus.fwd_ex_we),
    .ex_waddr_i (bus.fwd_ex_waddr),
    .ex_wdata_i (bus.fwd_ex_wdata),
    .mem_we_i   (bus.fwd_mem_we),
    .mem_waddr_i(bus.fwd_mem_waddr),
    .mem_wdata_i(bus.fwd_mem_wdata),
    .data_o     (rt_val),
    .ex_hit_o   (ex_hit2)
  );

  // A load in EX cannot forward until MEM, so any enabled port that matches it must wait.
  assign stall         = ~rst & bus.if_valid & bus.fwd_ex_is_load & (ex_hit1 | ex_hit2);
  assign bus.stall_req = stall;

  assign eq               = (rs_val == rt_val);
  assign bus.branch_taken = ~rst & bus.if_valid & ~stall & ~bus.flush &
                            ((dec.is_beq & eq) | (dec.is_bne & ~eq));
  assign br_offset         = {{(PC_W-18){imm[15]}}, imm, 2'b00};
  assign bus.branch_target = bus.if_pc + PC_W'(4) + br_offset;

  always_comb begin
    case (dec.op1_sel)
      OP1_SHAMT: opnd1 = {{(DATA_W-5){1'b0}}, shamt};
      OP1_ZERO:  opnd1 = DATA_W'(ZERO_WORD);
      default:   opnd1 = rs_val;
    endcase
    case (dec.op2_sel)
      OP2_SEXT: opnd2 = {{(DATA_W-16){imm[15]}}, imm};
      OP2_ZEXT: opnd2 = {{(DATA_W-16){1'b0}}, imm};
      OP2_LUI:  opnd2 = DATA_W'({imm, 16'h0000});
      default:  opnd2 = rt_val;
    endcase
  end

  always_comb begin
    // NOTE: every _d gets a bubble default first, so no path through this block infers a latch.
    idex_valid_d      = 1'b0;
    idex_aluop_d      = ALU_NOP;
    idex_opnd1_d      = '0;
    idex_opnd2_d      = '0;
    idex_we_d         = 1'b0;
    idex_waddr_d      = 5'd0;
    idex_mem_read_d   = 1'b0;
    idex_mem_write_d  = 1'b0;
    idex_store_data_d = '0;
    if (!bus.flush && !stall && bus.if_valid) begin
      idex_valid_d      = 1'b1;
      idex_aluop_d      = dec.alu_op;
      idex_opnd1_d      = opnd1;
      idex_opnd2_d      = opnd2;
      idex_we_d         = dec.we;
      idex_waddr_d      = dec.waddr;
      idex_mem_read_d   = dec.mem_read;
      idex_mem_write_d  = dec.mem_write;
      idex_store_data_d = rt_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid_q      <= 1'b0;
      idex_aluop_q      <= ALU_NOP;
      idex_opnd1_q      <= '0;
      idex_opnd2_q      <= '0;
      idex_we_q         <= 1'b0;
      idex_waddr_q      <= 5'd0;
      idex_mem_read_q   <= 1'b0;
      idex_mem_write_q  <= 1'b0;
      idex_store_data_q <= '0;
    end else begin
      idex_valid_q      <= idex_valid_d;
      idex_aluop_q      <= idex_aluop_d;
      idex_opnd1_q      <= idex_opnd1_d;
      idex_opnd2_q      <= idex_opnd2_d;
      idex_we_q         <= idex_we_d;
      idex_waddr_q      <= idex_waddr_d;
      idex_mem_read_q   <= idex_mem_read_d;
      idex_mem_write_q  <= idex_mem_write_d;
      idex_store_data_q <= idex_store_data_d;
    end
  end

  assign bus.idex_valid      = idex_valid_q;
  assign bus.idex_aluop      = idex_aluop_q;
  assign bus.idex_opnd1      = idex_opnd1_q;
  assign bus.idex_opnd2      = idex_opnd2_q;
  assign bus.idex_we         = idex_we_q;
  assign bus.idex_waddr      = idex_waddr_q;
  assign bus.idex_mem_read   = idex_mem_read_q;
  assign bus.idex_mem_write  = idex_mem_write_q;
  assign bus.idex_store_data = idex_store_data_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-encoded MIPS words with hand-computed ID/EX and
// combinational expectations, one task per scenario.
module tb_id_stage;
  import id_stage_pkg::*;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  id_stage_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

  id_stage #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // {valid, aluop, we, waddr, mem_read, mem_write}
  function automatic logic [12:0] ctrl_act();
    return {bus.idex_valid, bus.idex_aluop, bus.idex_we, bus.idex_waddr,
            bus.idex_mem_read, bus.idex_mem_write};
  endfunction

  function automatic logic [12:0] ctrl_exp(input logic v, input logic [3:0] op, input logic we,
                                           input logic [4:0] wa, input logic mr, input logic mw);
    return {v, op, we, wa, mr, mw};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_pc          = '0;
    bus.if_inst        = '0;
    bus.if_valid       = 1'b0;
    bus.reg1_data      = '0;
    bus.reg2_data      = '0;
    bus.fwd_ex_we      = 1'b0;
    bus.fwd_ex_waddr   = 5'd0;
    bus.fwd_ex_wdata   = '0;
    bus.fwd_ex_is_load = 1'b0;
    bus.fwd_mem_we     = 1'b0;
    bus.fwd_mem_waddr  = 5'd0;
    bus.fwd_mem_wdata  = '0;
    bus.flush          = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
    bus.if_pc    = pc;
    bus.if_inst  = inst;
    bus.if_valid = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    issue(32'h0, 32'h3401_8000);           // ORI $1,$0,0x8000 held during reset
    tick();
    tick();
    checks++;
    if ({ctrl_act(), bus.idex_opnd1, bus.idex_opnd2, bus.idex_store_data} !== '0) begin
      errors++;
      $display("FAIL reset_idex: got ctrl=%h o1=%h o2=%h sd=%h expected all 0",
               ctrl_act(), bus.idex_opnd1, bus.idex_opnd2, bus.idex_store_data);
    end
    checks++;
    if ({bus.reg1_read, bus.reg2_read, bus.stall_req, bus.branch_taken} !== 4'b0) begin
      errors++;
      $display("FAIL reset_comb: got %b expected 0000",
               {bus.reg1_read, bus.reg2_read, bus.stall_req, bus.branch_taken});
    end
    rst = 1'b0;
  endtask

  task automatic test_ori();
    clear_inputs();
    issue(32'h0, 32'h3401_8000);
    #1;
    checks++;
    if ({bus.reg1_read, bus.reg2_read, bus.reg1_addr} !== {1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL ori_reads: got %b expected 1000000", {bus.reg1_read, bus.reg2_read, bus.reg1_addr});
    end
    tick();
    checks++;
    if (ctrl_act() !== ctrl_exp(1'b1, ALU_OR, 1'b1, 5'd1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL ori_ctrl: got %h expected %h", ctrl_act(), ctrl_exp(1'b1, ALU_OR, 1'b1, 5'd1, 1'b0, 1'b0));
    end
    checks++;
    if ({bus.idex_opnd1, bus.idex_opnd2} !== {32'h0, 32'h0000_8000}) begin
      errors++;
      $display("FAIL ori_opnds: got %h %h expected 00000000 00008000", bus.idex_opnd1, bus.idex_opnd2);
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    issue(32'h4, 32'h0022_1821);           // ADDU $3,$1,$2
    bus.reg1_data     = 32'hDEAD;
    bus.reg2_data     = 32'd7;
    bus.fwd_ex_we     = 1'b1;
    bus.fwd_ex_waddr  = 5'd1;
    bus.fwd_ex_wdata  = 32'd5;
    bus.fwd_mem_we    = 1'b1;
    bus.fwd_mem_waddr = 5'd1;
    bus.fwd_mem_wdata = 32'd9;
    tick();
    checks++;
    if ({bus.idex_opnd1, bus.idex_opnd2} !== {32'd5, 32'd7}) begin
      errors++;
      $display("FAIL fwd_ex_prio: got %h %h expected 00000005 00000007", bus.idex_opnd1, bus.idex_opnd2);
    end
    checks++;
    if (ctrl_act() !== ctrl_exp(1'b1, ALU_ADD, 1'b1, 5'd3, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL addu_ctrl: got %h expected %h", ctrl_act(), ctrl_exp(1'b1, ALU_ADD, 1'b1, 5'd3, 1'b0, 1'b0));
    end
    bus.fwd_ex_we = 1'b0;
    tick();
    checks++;
    if (bus.idex_opnd1 !== 32'd9) begin
      errors++;
      $display("FAIL fwd_mem: got %h expected 00000009", bus.idex_opnd1);
    end
    bus.fwd_mem_we = 1'b0;
    tick();
    checks++;
    if (bus.idex_opnd1 !== 32'hDEAD) begin
      errors++;
      $display("FAIL fwd_rf: got %h expected 0000dead", bus.idex_opnd1);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    issue(32'h8, 32'h0080_2821);           // ADDU $5,$4,$0
    bus.fwd_ex_we      = 1'b1;
    bus.fwd_ex_is_load = 1'b1;
    bus.fwd_ex_waddr   = 5'd4;
    bus.fwd_ex_wdata   = 32'hBAD;
    #1;
    checks++;
    if (bus.stall_req !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got %b expected 1", bus.stall_req);
    end
    tick();
    checks++;
    if (ctrl_act() !== 13'd0) begin
      errors++;
      $display("FAIL lu_bubble: got %h expected 0000", ctrl_act());
    end
    bus.fwd_ex_we      = 1'b0;
    bus.fwd_ex_is_load = 1'b0;
    bus.fwd_mem_we     = 1'b1;
    bus.fwd_mem_waddr  = 5'd4;
    bus.fwd_mem_wdata  = 32'h11;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL lu_release: got %b expected 0", bus.stall_req);
    end
    tick();
    checks++;
    if ({ctrl_act(), bus.idex_opnd1} !== {ctrl_exp(1'b1, ALU_ADD, 1'b1, 5'd5, 1'b0, 1'b0), 32'h11}) begin
      errors++;
      $display("FAIL lu_issue: got %h %h expected %h 00000011", ctrl_act(), bus.idex_opnd1,
               ctrl_exp(1'b1, ALU_ADD, 1'b1, 5'd5, 1'b0, 1'b0));
    end
    // rt read port also triggers; a non-read rt field does not
    clear_inputs();
    bus.fwd_ex_we      = 1'b1;
    bus.fwd_ex_is_load = 1'b1;
    bus.fwd_ex_waddr   = 5'd4;
    issue(32'hC, 32'h0004_10C0);           // SLL $2,$4,3
    #1;
    checks++;
    if (bus.stall_req !== 1'b1) begin
      errors++;
      $display("FAIL lu_rt_stall: got %b expected 1", bus.stall_req);
    end
    issue(32'hC, 32'h3404_0001);           // ORI $4,$0,1
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL lu_no_read: got %b expected 0", bus.stall_req);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    issue(32'h100, 32'h1022_FFFF);         // BEQ $1,$2,-1
    bus.reg1_data = 32'd3;
    bus.reg2_data = 32'd3;
    #1;
    checks++;
    if ({bus.branch_taken, bus.branch_target} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL beq_taken: got %b %h expected 1 00000100", bus.branch_taken, bus.branch_target);
    end
    tick();
    checks++;
    if (ctrl_act() !== ctrl_exp(1'b1, ALU_NOP, 1'b0, 5'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL beq_nop: got %h expected %h", ctrl_act(), ctrl_exp(1'b1, ALU_NOP, 1'b0, 5'd0, 1'b0, 1'b0));
    end
    bus.reg2_data = 32'd4;
    #1;
    checks++;
    if (bus.branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL beq_not_taken: got %b expected 0", bus.branch_taken);
    end
    issue(32'hFFFF_0000, 32'h1422_7FFF);   // BNE $1,$2,0x7FFF
    bus.reg1_data = 32'd1;
    bus.reg2_data = 32'd2;
    #1;
    checks++;
    if ({bus.branch_taken, bus.branch_target} !== {1'b1, 32'h0001_0000}) begin
      errors++;
      $display("FAIL bne_wrap: got %b %h expected 1 00010000", bus.branch_taken, bus.branch_target);
    end
    issue(32'h100, 32'h1022_FFFF);
    bus.reg2_data = 32'd1;
    bus.flush     = 1'b1;
    #1;
    checks++;
    if (bus.branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL beq_flush: got %b expected 0", bus.branch_taken);
    end
    bus.flush          = 1'b0;
    bus.fwd_ex_we      = 1'b1;
    bus.fwd_ex_is_load = 1'b1;
    bus.fwd_ex_waddr   = 5'd1;
    #1;
    checks++;
    if ({bus.stall_req, bus.branch_taken} !== 2'b10) begin
      errors++;
      $display("FAIL beq_stall: got %b expected 10", {bus.stall_req, bus.branch_taken});
    end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    issue(32'h10, 32'h0000_0000);          // SLL $0,$0,0
    #1;
    checks++;
    if ({bus.reg1_read, bus.reg2_read} !== 2'b01) begin
      errors++;
      $display("FAIL sll_reads: got %b expected 01", {bus.reg1_read, bus.reg2_read});
    end
    tick();
    checks++;
    if (ctrl_act() !== ctrl_exp(1'b1, ALU_SLL, 1'b0, 5'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL sll_nop: got %h expected %h", ctrl_act(), ctrl_exp(1'b1, ALU_SLL, 1'b0, 5'd0, 1'b0, 1'b0));
    end
    issue(32'h14, 32'h2420_0005);          // ADDIU $0,$1,5
    tick();
    checks++;
    if ({bus.idex_valid, bus.idex_we, bus.idex_opnd2} !== {1'b1, 1'b0, 32'd5}) begin
      errors++;
      $display("FAIL addiu_r0: got %b %b %h expected 1 0 00000005", bus.idex_valid, bus.idex_we, bus.idex_opnd2);
    end
    issue(32'h18, 32'h0002_1821);          // ADDU $3,$0,$2
    bus.fwd_ex_we      = 1'b1;
    bus.fwd_ex_is_load = 1'b1;
    bus.fwd_ex_waddr   = 5'd0;
    bus.fwd_ex_wdata   = 32'h55;
    bus.reg2_data      = 32'h22;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL r0_no_stall: got %b expected 0", bus.stall_req);
    end
    tick();
    checks++;
    if ({bus.idex_opnd1, bus.idex_opnd2} !== {32'h0, 32'h22}) begin
      errors++;
      $display("FAIL r0_no_fwd: got %h %h expected 00000000 00000022", bus.idex_opnd1, bus.idex_opnd2);
    end
  endtask

  task automatic test_mem_ops();
    clear_inputs();
    bus.reg1_data = 32'h1000;
    bus.reg2_data = 32'hCAFE;
    issue(32'h20, 32'h8C26_FFF8);          // LW $6,-8($1)
    tick();
    checks++;
    if ({ctrl_act(), bus.idex_opnd1, bus.idex_opnd2} !==
        {ctrl_exp(1'b1, ALU_ADD, 1'b1, 5'd6, 1'b1, 1'b0), 32'h1000, 32'hFFFF_FFF8}) begin
      errors++;
      $display("FAIL lw: got %h %h %h expected %h 00001000 fffffff8", ctrl_act(), bus.idex_opnd1,
               bus.idex_opnd2, ctrl_exp(1'b1, ALU_ADD, 1'b1, 5'd6, 1'b1, 1'b0));
    end
    issue(32'h24, 32'hAC27_0004);          // SW $7,4($1)
    tick();
    checks++;
    if ({ctrl_act(), bus.idex_opnd2, bus.idex_store_data} !==
        {ctrl_exp(1'b1, ALU_ADD, 1'b0, 5'd0, 1'b0, 1'b1), 32'd4, 32'hCAFE}) begin
      errors++;
      $display("FAIL sw: got %h %h %h expected %h 00000004 0000cafe", ctrl_act(), bus.idex_opnd2,
               bus.idex_store_data, ctrl_exp(1'b1, ALU_ADD, 1'b0, 5'd0, 1'b0, 1'b1));
    end
    bus.reg1_data = 32'hFFFF;
    issue(32'h28, 32'h3C08_1234);          // LUI $8,0x1234
    #1;
    checks++;
    if (bus.reg1_read !== 1'b0) begin
      errors++;
      $display("FAIL lui_read: got %b expected 0", bus.reg1_read);
    end
    tick();
    checks++;
    if ({ctrl_act(), bus.idex_opnd1, bus.idex_opnd2} !==
        {ctrl_exp(1'b1, ALU_OR, 1'b1, 5'd8, 1'b0, 1'b0), 32'h0, 32'h1234_0000}) begin
      errors++;
      $display("FAIL lui: got %h %h %h expected %h 00000000 12340000", ctrl_act(), bus.idex_opnd1,
               bus.idex_opnd2, ctrl_exp(1'b1, ALU_OR, 1'b1, 5'd8, 1'b0, 1'b0));
    end
    issue(32'h2C, 32'hFC00_0000);          // undefined opcode 0x3F
    tick();
    checks++;
    if (ctrl_act() !== ctrl_exp(1'b1, ALU_NOP, 1'b0, 5'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL undef_nop: got %h expected %h", ctrl_act(), ctrl_exp(1'b1, ALU_NOP, 1'b0, 5'd0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    issue(32'h30, 32'h3441_8000);          // ORI $1,$2,0x8000
    bus.fwd_ex_we      = 1'b1;
    bus.fwd_ex_is_load = 1'b1;
    bus.fwd_ex_waddr   = 5'd2;
    bus.flush          = 1'b1;
    tick();
    checks++;
    if (ctrl_act() !== 13'd0) begin
      errors++;
      $display("FAIL flush_stall: got %h expected 0000", ctrl_act());
    end
    bus.fwd_ex_we      = 1'b0;
    bus.fwd_ex_is_load = 1'b0;
    tick();
    checks++;
    if (bus.idex_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_only: got %b expected 0", bus.idex_valid);
    end
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    tick();
    checks++;
    if (bus.idex_valid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_bubble: got %b expected 0", bus.idex_valid);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    issue(32'h40, 32'h3401_8000);
    tick();
    checks++;
    if (bus.idex_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_valid: got %b expected 1", bus.idex_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.reg1_read !== 1'b0) begin
      errors++;
      $display("FAIL rst_read: got %b expected 0", bus.reg1_read);
    end
    tick();
    checks++;
    if ({ctrl_act(), bus.idex_opnd1, bus.idex_opnd2, bus.idex_store_data} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got ctrl=%h o2=%h expected all 0", ctrl_act(), bus.idex_opnd2);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ori();
    test_forwarding();
    test_load_use();
    test_branch();
    test_zero_reg();
    test_mem_ops();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
